// File: rtl/ksa_seq_adder_if.sv
// Request/response bundle for the sequential Kogge-Stone adder.
// Slave is the adder; master is whatever feeds operands and drains results.
interface ksa_seq_adder_if #(
  parameter int W = 44
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/ksa_seq_adder.sv
// Wide add/subtract built from one narrow Kogge-Stone adder reused over
// NUM_CHUNKS cycles, least significant chunk first, with a valid/ready handshake.

module ksa_adder #(
  parameter int data_size = 11
) (
  input  logic [data_size-1:0] a,
  input  logic [data_size-1:0] b,
  input  logic                 cin,
  output logic [data_size-1:0] sum,
  output logic                 cout
);
  localparam int LEVELS = (data_size > 1) ? $clog2(data_size) : 1;

  logic [data_size-1:0] prop;
  logic [data_size-1:0] carry;

  assign prop = a ^ b;

  // cin is folded into bit 0's generate so the prefix tree yields true carries.
  always_comb begin
    logic [data_size-1:0] g_c, p_c, g_n, p_n;
    g_c    = a & b;
    p_c    = a ^ b;
    g_c[0] = g_c[0] | (p_c[0] & cin);
    for (int l = 0; l < LEVELS; l++) begin
      g_n = g_c;
      p_n = p_c;
      for (int i = (1 << l); i < data_size; i++) begin
        g_n[i] = g_c[i] | (p_c[i] & g_c[i - (1 << l)]);
        p_n[i] = p_c[i] & p_c[i - (1 << l)];
      end
      g_c = g_n;
      p_c = p_n;
    end
    carry = g_c;
  end

  assign sum  = prop ^ {carry[data_size-2:0], cin};
  assign cout = carry[data_size-1];
endmodule

module ksa_seq_adder #(
  parameter int DATA_SIZE  = 11,
  parameter int NUM_CHUNKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ksa_seq_adder_if.slave     bus,
  output logic               busy
);
  localparam int W  = DATA_SIZE * NUM_CHUNKS;
  localparam int CW = $clog2(NUM_CHUNKS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;

  int                   chunk_base;
  logic [DATA_SIZE-1:0] chunk_a, chunk_b, chunk_sum;
  logic                 chunk_cout;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign chunk_base = int'(idx_q) * DATA_SIZE;
  assign chunk_a    = a_q[chunk_base +: DATA_SIZE];
  assign chunk_b    = b_q[chunk_base +: DATA_SIZE];

  ksa_adder #(.data_size(DATA_SIZE)) u_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1, so B is inverted and the carry forced.
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub ? 1'b1 : bus.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[chunk_base +: DATA_SIZE] = chunk_sum;
        carry_d = chunk_cout;
        idx_d   = idx_q + CW'(1);
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  assign bus.out_ovf   = signed_ovf(a_q[W-1], b_q[W-1], sum_q[W-1]);
endmodule
